// File: rtl/mipi_pkg.sv
// rtl/mipi_pkg.sv - shared state encoding, data-type constants and CRC-16 helper for the MIPI packet decoder
package mipi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_HDR,
      ST_PAYLOAD,
      ST_CRC,
      ST_DRAIN
   } state_t;

   localparam logic [5:0]  DT_FS       = 6'h00;
   localparam logic [5:0]  DT_FE       = 6'h01;
   localparam logic [5:0]  DT_LS       = 6'h02;
   localparam logic [5:0]  DT_LE       = 6'h03;
   localparam logic [5:0]  DT_LONG_MIN = 6'h10;

   localparam logic [7:0]  SYNC_BYTE   = 8'hB8;

   localparam logic [15:0] CRC_INIT    = 16'hFFFF;
   localparam logic [15:0] CRC_POLY    = 16'h8408;

   // Reflected CRC-16 (0x1021), one byte consumed LSB first.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ b[i]) c = (c >> 1) ^ CRC_POLY;
         else             c = c >> 1;
      end
      return c;
   endfunction

endpackage

// File: rtl/mipi_crc16.sv
// rtl/mipi_crc16.sv - byte-wide CRC-16 accumulator over long-packet payload bytes
module mipi_crc16
   import mipi_pkg::*;
(
   input  logic        clk,
   input  logic        resetb,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [15:0] crc
);

   logic [15:0] crc_next;

   always_comb begin
      crc_next = crc16_byte(crc, data);
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb)   crc <= CRC_INIT;
      else if (init) crc <= CRC_INIT;
      else if (en)   crc <= crc_next;
   end

endmodule

// File: rtl/mipi_packet_decoder.sv
// rtl/mipi_packet_decoder.sv - CSI-2 style byte-stream packet decoder (sync, header, payload, CRC)
// Payload CRC checking is built only when MIPI_CRC_CHECK_EN is defined.
module mipi_packet_decoder
   import mipi_pkg::*;
#(
   parameter logic [1:0]  VC_SEL = 2'd0,
   parameter logic [15:0] MAX_WC = 16'd8192
)(
   input  logic        clk,
   input  logic        resetb,
   input  logic        we,
   input  logic [7:0]  data,
   output logic [7:0]  dout,
   output logic        dout_valid,
   output logic [5:0]  data_type,
   output logic [15:0] word_count,
   output logic        frame_start,
   output logic        frame_end,
   output logic        line_start,
   output logic        line_end,
   output logic        pkt_err,
   output logic        crc_err
);

   state_t      state, state_next;
   logic [1:0]  rst_sync;
   logic        ready;
   logic [1:0]  hdr_idx;
   logic [7:0]  di_reg;
   logic [7:0]  wc_lsb;
   logic [15:0] cnt;
   logic        crc_idx;
   logic        fs_n, fe_n, ls_n, le_n, perr_n;

   assign ready = rst_sync[1];

`ifdef MIPI_CRC_CHECK_EN
   logic [15:0] crc_val;
   logic [7:0]  crc_lsb;
   logic        cerr_n;
   logic        crc_init;
   logic        crc_en;

   assign crc_init = we && (state == ST_HDR) && (hdr_idx == 2'd2);
   assign crc_en   = we && (state == ST_PAYLOAD);

   mipi_crc16 u_crc16 (
      .clk    (clk),
      .resetb (resetb),
      .init   (crc_init),
      .en     (crc_en),
      .data   (data),
      .crc    (crc_val)
   );
`endif

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) state <= ST_IDLE;
      else         state <= state_next;
   end

   // SYNC consumes the DI byte; HDR then sees WC LSB (0), WC MSB (1), ECC (2).
   always_comb begin
      state_next = state;
      fs_n       = 1'b0;
      fe_n       = 1'b0;
      ls_n       = 1'b0;
      le_n       = 1'b0;
      perr_n     = 1'b0;
`ifdef MIPI_CRC_CHECK_EN
      cerr_n     = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (we && ready) begin
               if (data == SYNC_BYTE) begin
                  state_next = ST_SYNC;
               end else begin
                  perr_n     = 1'b1;
                  state_next = ST_DRAIN;
               end
            end
         end
         ST_SYNC: begin
            if (!we) begin
               perr_n     = 1'b1;
               state_next = ST_IDLE;
            end else begin
               state_next = ST_HDR;
            end
         end
         ST_HDR: begin
            if (!we) begin
               perr_n     = 1'b1;
               state_next = ST_IDLE;
            end else if (hdr_idx == 2'd2) begin
               if (di_reg[7:6] != VC_SEL) begin
                  state_next = ST_DRAIN;
               end else if (data_type < DT_LONG_MIN) begin
                  state_next = ST_DRAIN;
                  fs_n       = (data_type == DT_FS);
                  fe_n       = (data_type == DT_FE);
                  ls_n       = (data_type == DT_LS);
                  le_n       = (data_type == DT_LE);
               end else if (word_count == 16'd0) begin
                  state_next = ST_CRC;
               end else if (word_count > MAX_WC) begin
                  perr_n     = 1'b1;
                  state_next = ST_DRAIN;
               end else begin
                  state_next = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            if (!we) begin
               perr_n     = 1'b1;
               state_next = ST_IDLE;
            end else if (cnt == 16'd1) begin
               le_n       = 1'b1;
               state_next = ST_CRC;
            end
         end
         ST_CRC: begin
            if (!we) begin
               perr_n     = 1'b1;
               state_next = ST_IDLE;
            end else if (crc_idx) begin
               state_next = ST_DRAIN;
`ifdef MIPI_CRC_CHECK_EN
               cerr_n     = ({data, crc_lsb} != crc_val);
`endif
            end
         end
         ST_DRAIN: begin
            if (!we) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         rst_sync    <= 2'b00;
         hdr_idx     <= 2'd0;
         di_reg      <= 8'h00;
         wc_lsb      <= 8'h00;
         cnt         <= 16'd0;
         crc_idx     <= 1'b0;
         dout        <= 8'h00;
         dout_valid  <= 1'b0;
         data_type   <= 6'h00;
         word_count  <= 16'd0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         line_start  <= 1'b0;
         line_end    <= 1'b0;
         pkt_err     <= 1'b0;
      end else begin
         rst_sync    <= {rst_sync[0], 1'b1};
         dout_valid  <= 1'b0;
         frame_start <= fs_n;
         frame_end   <= fe_n;
         line_start  <= ls_n;
         line_end    <= le_n;
         pkt_err     <= perr_n;
         if (we) begin
            case (state)
               ST_SYNC: begin
                  di_reg  <= data;
                  hdr_idx <= 2'd0;
               end
               ST_HDR: begin
                  hdr_idx <= hdr_idx + 2'd1;
                  crc_idx <= 1'b0;
                  if (hdr_idx == 2'd0) wc_lsb <= data;
                  if (hdr_idx == 2'd1) begin
                     data_type  <= di_reg[5:0];
                     word_count <= {data, wc_lsb};
                  end
                  if (hdr_idx == 2'd2) cnt <= word_count;
               end
               ST_PAYLOAD: begin
                  dout       <= data;
                  dout_valid <= 1'b1;
                  cnt        <= cnt - 16'd1;
               end
               ST_CRC: crc_idx <= 1'b1;
               default: ;
            endcase
         end
      end
   end

`ifdef MIPI_CRC_CHECK_EN
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         crc_lsb <= 8'h00;
         crc_err <= 1'b0;
      end else begin
         crc_err <= cerr_n;
         if (we && (state == ST_CRC)) crc_lsb <= data;
      end
   end
`else
   assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_mipi_packet_decoder.sv
// tb/tb_mipi_packet_decoder.sv - directed self-checking bench for mipi_packet_decoder
module tb_mipi_packet_decoder;

   logic        clk;
   logic        resetb;
   logic        we;
   logic [7:0]  data;
   logic [7:0]  dout;
   logic        dout_valid;
   logic [5:0]  data_type;
   logic [15:0] word_count;
   logic        frame_start, frame_end, line_start, line_end, pkt_err, crc_err;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] bq[$];
   logic [7:0] dq[$];
   int fs_cnt, fe_cnt, ls_cnt, le_cnt, perr_cnt, cerr_cnt, le_last_cnt, run, max_run;

   mipi_packet_decoder dut (
      .clk         (clk),
      .resetb      (resetb),
      .we          (we),
      .data        (data),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .data_type   (data_type),
      .word_count  (word_count),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .line_start  (line_start),
      .line_end    (line_end),
      .pkt_err     (pkt_err),
      .crc_err     (crc_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (dout_valid) begin
         dq.push_back(dout);
         run = run + 1;
         if (run > max_run) max_run = run;
      end else begin
         run = 0;
      end
      fs_cnt      = fs_cnt + int'(frame_start);
      fe_cnt      = fe_cnt + int'(frame_end);
      ls_cnt      = ls_cnt + int'(line_start);
      le_cnt      = le_cnt + int'(line_end);
      perr_cnt    = perr_cnt + int'(pkt_err);
      cerr_cnt    = cerr_cnt + int'(crc_err);
      le_last_cnt = le_last_cnt + int'(line_end && dout_valid);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[0] ^ b[i];
         r  = {1'b0, r[15:1]};
         if (fb) r = r ^ 16'h8408;
      end
      return r;
   endfunction

   task automatic clr();
      @(posedge clk);
      #1;
      dq.delete();
      fs_cnt = 0; fe_cnt = 0; ls_cnt = 0; le_cnt = 0;
      perr_cnt = 0; cerr_cnt = 0; le_last_cnt = 0; run = 0; max_run = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      we   = 1'b1;
      data = b;
   endtask

   task automatic send_burst();
      foreach (bq[i]) send_byte(bq[i]);
      @(negedge clk);
      we   = 1'b0;
      data = 8'h00;
      repeat (6) @(negedge clk);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_lo"}, {17'd0, dout, dout_valid, data_type}, 32'd0);
      check({tag, "_hi"}, {10'd0, word_count, frame_start, frame_end, line_start,
                           line_end, pkt_err, crc_err}, 32'd0);
   endtask

   initial begin
      logic [15:0] crc;
      logic [7:0]  last_b;
      int          cerr_exp;

      resetb = 1'b0;
      we     = 1'b0;
      data   = 8'h00;
      fs_cnt = 0; fe_cnt = 0; ls_cnt = 0; le_cnt = 0;
      perr_cnt = 0; cerr_cnt = 0; le_last_cnt = 0; run = 0; max_run = 0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      resetb = 1'b1;
      repeat (3) @(negedge clk);

      // frame start short packet; strobe must appear the cycle after ECC
      clr();
      bq = '{8'hB8, 8'h00, 8'h00, 8'h00, 8'h5A};
      foreach (bq[i]) send_byte(bq[i]);
      @(negedge clk);
      check("fs_timing", 32'(frame_start), 32'd1);
      we = 1'b0;
      repeat (6) @(negedge clk);
      check("fs_count", fs_cnt, 1);
      check("fs_others", fe_cnt + ls_cnt + le_cnt + perr_cnt + cerr_cnt + dq.size(), 0);

      // four-byte long packet with correct CRC
      clr();
      crc = 16'hFFFF;
      crc = crc_upd(crc, 8'h11);
      crc = crc_upd(crc, 8'h22);
      crc = crc_upd(crc, 8'h33);
      crc = crc_upd(crc, 8'h44);
      bq = '{8'hB8, 8'h2A, 8'h04, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, crc[7:0], crc[15:8]};
      send_burst();
      check("lp_count", dq.size(), 4);
      if (dq.size() == 4) begin
         check("lp_b0", dq[0], 8'h11);
         check("lp_b1", dq[1], 8'h22);
         check("lp_b2", dq[2], 8'h33);
         check("lp_b3", dq[3], 8'h44);
      end
      check("lp_run", max_run, 4);
      check("lp_le", le_cnt, 1);
      check("lp_le_last", le_last_cnt, 1);
      check("lp_wc", word_count, 16'd4);
      check("lp_dt", data_type, 6'h2A);
      check("lp_perr", perr_cnt, 0);
      check("lp_cerr", cerr_cnt, 0);

      // zero-length packet, good CRC
      clr();
      bq = '{8'hB8, 8'h2A, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
      send_burst();
      check("wc0_cerr", cerr_cnt, 0);
      check("wc0_out", dq.size() + le_cnt + perr_cnt, 0);

      // zero-length packet, bad CRC
      clr();
      bq = '{8'hB8, 8'h2A, 8'h00, 8'h00, 8'h00, 8'hFE, 8'hFF};
      send_burst();
`ifdef MIPI_CRC_CHECK_EN
      cerr_exp = 1;
`else
      cerr_exp = 0;
`endif
      check("badcrc_cerr", cerr_cnt, cerr_exp);

      // bad sync byte, then a good line-start packet
      clr();
      bq = '{8'h5C, 8'h00, 8'h00, 8'h00, 8'h00};
      send_burst();
      check("badsync_perr", perr_cnt, 1);
      check("badsync_out", fs_cnt + le_cnt + dq.size(), 0);
      clr();
      bq = '{8'hB8, 8'h02, 8'h00, 8'h00, 8'h00};
      send_burst();
      check("after_sync_ls", ls_cnt, 1);
      check("after_sync_perr", perr_cnt, 0);

      // burst ends after two of four payload bytes, then a line-end packet
      clr();
      bq = '{8'hB8, 8'h2A, 8'h04, 8'h00, 8'h00, 8'h11, 8'h22};
      send_burst();
      check("abort_count", dq.size(), 2);
      check("abort_perr", perr_cnt, 1);
      check("abort_le", le_cnt, 0);
      clr();
      bq = '{8'hB8, 8'h03, 8'h00, 8'h00, 8'h00};
      send_burst();
      check("after_abort_le", le_cnt, 1);
      check("after_abort_perr", perr_cnt, 0);

      // other virtual channel: header fields still update, nothing else happens
      clr();
      bq = '{8'hB8, 8'h42, 8'h04, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
      send_burst();
      check("vc_out", dq.size() + ls_cnt + le_cnt + perr_cnt, 0);
      check("vc_dt", data_type, 6'h02);
      check("vc_wc", word_count, 16'd4);

      // word count one above the limit
      clr();
      bq = '{8'hB8, 8'h2A, 8'h01, 8'h20, 8'h00, 8'h11, 8'h22};
      send_burst();
      check("wcmax_perr", perr_cnt, 1);
      check("wcmax_out", dq.size() + le_cnt, 0);

      // word count exactly at the limit
      clr();
      crc = 16'hFFFF;
      bq = '{8'hB8, 8'h2A, 8'h00, 8'h20, 8'h00};
      last_b = 8'h00;
      for (int i = 0; i < 8192; i++) begin
         last_b = 8'(i) ^ 8'h5A;
         bq.push_back(last_b);
         crc = crc_upd(crc, last_b);
      end
      bq.push_back(crc[7:0]);
      bq.push_back(crc[15:8]);
      send_burst();
      check("wclim_count", dq.size(), 8192);
      if (dq.size() == 8192) check("wclim_last", dq[8191], last_b);
      check("wclim_le", le_cnt, 1);
      check("wclim_perr", perr_cnt, 0);
      check("wclim_cerr", cerr_cnt, 0);

      // reset asserted in the middle of a payload
      clr();
      bq = '{8'hB8, 8'h2A, 8'h08, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
      foreach (bq[i]) send_byte(bq[i]);
      @(posedge clk);
      #2;
      resetb = 1'b0;
      #1;
      check_zero_outputs("midrst");
      @(negedge clk);
      we = 1'b0;
      repeat (3) @(negedge clk);
      check_zero_outputs("midrst_hold");
      resetb = 1'b1;
      clr();
      repeat (4) @(negedge clk);
      check("midrst_after", dq.size() + perr_cnt + le_cnt, 0);
      clr();
      bq = '{8'hB8, 8'h01, 8'h00, 8'h00, 8'h00};
      send_burst();
      check("midrst_fe", fe_cnt, 1);
      check("midrst_fe_perr", perr_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mipi_packet_decoder.md
MIPI_PACKET_DECODER -- requirements
Module: mipi_packet_decoder

Interface
REQ-001 SHALL have parameter VC_SEL, default 2'd0: virtual channel accepted; packets on other VCs are discarded.
REQ-002 SHALL have parameter MAX_WC, default 16'd8192: largest long-packet word count accepted; larger counts abort the packet.
REQ-003 SHALL have port clk, in, 1: byte clock, the same clock as the upstream PHY deserializer output.
REQ-004 SHALL have port resetb, in, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port we, in, 1: byte valid from the deserializer; its deassertion marks end of HS burst.
REQ-006 SHALL have port data, in, 8: deserialized, word-aligned byte.
REQ-007 SHALL have port dout, out, 8: payload byte.
REQ-008 SHALL have port dout_valid, out, 1: dout qualifier.
REQ-009 SHALL have port data_type, out, 6: DT of the current or last packet, held until the next header.
REQ-010 SHALL have port word_count, out, 16: WC of the current or last packet, held until the next header.
REQ-011 SHALL have port frame_start, out, 1: one-cycle pulse on short packet DT 0x00.
REQ-012 SHALL have port frame_end, out, 1: one-cycle pulse on short packet DT 0x01.
REQ-013 SHALL have port line_start, out, 1: one-cycle pulse on DT 0x02.
REQ-014 SHALL have port line_end, out, 1: one-cycle pulse on DT 0x03, or one cycle after the last payload byte of a long packet.
REQ-015 SHALL have port pkt_err, out, 1: one-cycle pulse on sync/abort/WC error.
REQ-016 SHALL have port crc_err, out, 1: one-cycle pulse on payload CRC mismatch.

Function
REQ-017 SHALL implement states IDLE, SYNC, HDR, PAYLOAD, CRC, DRAIN.
REQ-018 IDLE -> SYNC on the first cycle with we=1; that byte SHALL equal 8'hB8 and be discarded. Otherwise: pulse pkt_err, go to DRAIN.
REQ-019 HDR collects 4 bytes: DI {VC[7:6],DT[5:0]}, WC LSB, WC MSB, ECC. ECC is ignored.
REQ-020 After the ECC byte, on VC mismatch -> DRAIN, with no pulses.
REQ-021 After the ECC byte, DT<0x10 -> DRAIN; the matching strobe (REQ-011..014) pulses the cycle after the ECC byte.
REQ-022 After the ECC byte, DT>=0x10 with WC=0 -> CRC.
REQ-023 After the ECC byte, DT>=0x10 with WC>MAX_WC -> pkt_err, DRAIN.
REQ-024 After the ECC byte, any other DT>=0x10 -> PAYLOAD.
REQ-025 PAYLOAD forwards exactly WC bytes: dout/dout_valid registered, 1-cycle latency; 16-bit down-counter; no wrap.
REQ-026 CRC consumes 2 bytes (LSB first), then -> DRAIN.
REQ-027 DRAIN ignores bytes until we=0, then -> IDLE.
REQ-028 we=0 in SYNC/HDR/PAYLOAD/CRC SHALL abort: pulse pkt_err, suppress line_end, go directly to IDLE; a partial payload already output stands.
REQ-029 A cycle with we=0 while in IDLE produces no action; bytes only count on cycles with we=1.
REQ-030 data_type/word_count SHALL update the cycle after the WC MSB byte, including for discarded VCs.

Reset
REQ-031 resetb low SHALL asynchronously force the state to IDLE, the counter to 0, and all outputs to 0 (dout, data_type, word_count included).
REQ-032 Release SHALL be synchronized internally with a 2-flop synchronizer; the first packet may start on the second clk after release.
REQ-033 Reset mid-packet SHALL drop the packet silently, with no pulse.

Configuration
REQ-034 Macro MIPI_CRC_CHECK_EN defined: CRC-16 (poly 0x1021 reflected 0x8408, init 0xFFFF, LSB-first) SHALL run over the payload bytes.
REQ-035 With the macro, the received CRC SHALL be compared to the computed value; crc_err pulses the cycle after the second CRC byte on mismatch.
REQ-036 Without the macro, crc_err SHALL be tied 0, the CRC bytes are skipped, and no CRC logic is synthesized.

Structure
REQ-037 Shared package mipi_pkg SHALL hold the state encoding, DT constants (FS/FE/LS/LE, long threshold 0x10), SYNC_BYTE 8'hB8, and CRC_INIT/CRC_POLY.
REQ-038 Sub-module mipi_crc16 SHALL provide byte-wide combinational next-CRC plus a registered accumulator, instantiated only under MIPI_CRC_CHECK_EN.

Verification
REQ-039 Burst B8,00,00,00,xx, then we=0 -> frame_start=1 for exactly 1 cycle, no other outputs.
REQ-040 Burst B8,2A,04,00,xx,11,22,33,44,crc -> dout 11,22,33,44 on 4 consecutive valid cycles, line_end once, word_count=4, data_type=0x2A.
REQ-041 Burst B8,2A,00,00,xx,FF,FF with macro -> crc_err=0.
REQ-042 Burst B8,2A,00,00,xx,FE,FF with macro -> crc_err=1; without macro -> crc_err=0.
REQ-043 Burst starting 0x5C, or we=0 after 2 of 4 payload bytes -> pkt_err pulse, no line_end, next valid burst decoded normally.
REQ-044 Burst B8,42 (VC=1),04,00,...; or resetb asserted mid-payload -> no dout_valid after the event, all outputs 0 during reset.
